// File: rtl/alu_control_sequencer.sv
// Four-state ALU sequencer: DECODE, EXECUTE strobe, WRITEBACK; wr_en is high in the third cycle after the accept edge.
// Takes at most one instruction every four cycles; instr_ready is high only in IDLE, and instr_valid is ignored elsewhere.
module alu_control_sequencer #(
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [7:0]                instr,
  input  logic                      alu_overflow,
  output logic                      alu_add,
  output logic                      alu_sub,
  output logic                      alu_and,
  output logic                      alu_or,
  output logic                      alu_xor,
  output logic                      alu_inv,
  output logic                      alu_clr,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr,
  output logic                      ovf_flag,
  output logic                      illegal,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_INV = 4'd6;
  localparam logic [3:0] OP_CLR = 4'd7;

  state_t     state_q, state_d;
  logic [7:0] instr_q;
  logic [3:0] opcode;
  logic       accept;
  logic       writes_rd;

  assign opcode    = instr_q[7:4];
  assign accept    = instr_valid && (state_q == IDLE);
  // Opcodes 1-7 write rd; NOP and the undefined upper half do not.
  assign writes_rd = !opcode[3] && (opcode != OP_NOP);

  // Addresses come straight from the captured instruction, so they hold
  // their last value in IDLE until the next accept.
  assign rs1_addr = REG_ADDR_WIDTH'(instr_q[3:2]);
  assign rs2_addr = REG_ADDR_WIDTH'(instr_q[1:0]);
  assign wr_addr  = REG_ADDR_WIDTH'(instr_q[3:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= 8'h00;
      illegal  <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= instr;
        illegal <= instr[7];
      end
      // Overflow lands on the EXECUTE->WRITEBACK edge so it is visible in WRITEBACK.
      if (state_q == EXECUTE) begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ovf_flag <= alu_overflow;
        end else if (opcode == OP_CLR) begin
          ovf_flag <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    alu_add     = 1'b0;
    alu_sub     = 1'b0;
    alu_and     = 1'b0;
    alu_or      = 1'b0;
    alu_xor     = 1'b0;
    alu_inv     = 1'b0;
    alu_clr     = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      EXECUTE: begin
        case (opcode)
          OP_ADD:  alu_add = 1'b1;
          OP_SUB:  alu_sub = 1'b1;
          OP_AND:  alu_and = 1'b1;
          OP_OR:   alu_or  = 1'b1;
          OP_XOR:  alu_xor = 1'b1;
          OP_INV:  alu_inv = 1'b1;
          OP_CLR:  alu_clr = 1'b1;
          default: ;
        endcase
      end
      WRITEBACK: wr_en = writes_rd;
      default: ;
    endcase
  end

endmodule

// File: doc/alu_control_sequencer.md
ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

Interface
REQ-001 The block SHALL have parameter REG_ADDR_WIDTH, 2, register-file address width; instruction width is fixed at 8 bits.
REQ-002 The block SHALL have one clock (clk) and one asynchronous active-low reset (rst_n); reset assertion takes effect without a clock edge.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 instr_valid  in  1  upstream has an instruction on instr.
REQ-006 instr_ready  out  1  sequencer can accept an instruction.
REQ-007 instr  in  8  fields: [7:4] opcode, [3:2] rd (also rs1), [1:0] rs2.
REQ-008 alu_overflow  in  1  ALU overflow output, sampled in EXECUTE.
REQ-009 alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr  out  1 each  ALU operation strobes; at most one high in any cycle.
REQ-010 rs1_addr, rs2_addr  out  2 each  register-file read addresses.
REQ-011 wr_en  out  1  register-file write strobe.
REQ-012 wr_addr  out  2  register-file write address.
REQ-013 ovf_flag  out  1  overflow status of the last ADD/SUB.
REQ-014 illegal  out  1  last accepted opcode was undefined.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, DECODE, EXECUTE, WRITEBACK. Transitions: IDLE->DECODE on instr_valid&&instr_ready; DECODE->EXECUTE; EXECUTE->WRITEBACK; WRITEBACK->IDLE. All transitions are unconditional except the one leaving IDLE.
REQ-017 instr_ready SHALL be high only in IDLE. instr SHALL be captured into an internal register on the accepting edge. instr_valid outside IDLE SHALL be ignored.
REQ-018 Opcode map: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 INV, 7 CLR, 8-15 undefined.
REQ-019 rs1_addr and rs2_addr SHALL be driven from the captured instr[3:2] and instr[1:0] from DECODE through WRITEBACK. Otherwise they hold their last value.
REQ-020 In EXECUTE, exactly one strobe SHALL be high for one cycle, matching the opcode. No strobe SHALL be high for NOP or undefined opcodes.
REQ-021 In WRITEBACK, wr_en SHALL be high for one cycle, with wr_addr equal to the captured instr[3:2], for opcodes 1-7 only.
REQ-022 wr_en SHALL be low for NOP and for undefined opcodes.
REQ-023 alu_overflow SHALL be registered at the end of EXECUTE for ADD/SUB. ovf_flag SHALL take that value from WRITEBACK onward.
REQ-024 ovf_flag SHALL be cleared by CLR. It SHALL be unchanged by NOP, the logic operations and undefined opcodes.
REQ-025 illegal SHALL be set in DECODE when the opcode is 8-15, and cleared in DECODE for any defined opcode.
REQ-026 Latency: accept edge to wr_en high is 3 cycles. Maximum throughput is one instruction per 4 cycles. instr_ready returns high in the cycle after WRITEBACK.
REQ-027 Back-to-back: with instr_valid held high, the next instruction SHALL be accepted on the first IDLE cycle. There SHALL be no bubble beyond IDLE.

Reset
REQ-028 On rst_n low: state=IDLE; instr_ready=1 after release; all strobes, wr_en, ovf_flag, illegal, busy=0; rs1_addr, rs2_addr, wr_addr and the captured instr=0.
REQ-029 Reset asserted in any state, including mid-EXECUTE or mid-WRITEBACK, SHALL abort the instruction: no strobe or wr_en may be high once reset is asserted, and the instruction is not resumed.

Verification
REQ-030 Accept instr=0x16 (ADD rd=1, rs2=2) with alu_overflow=0 -> rs1_addr=1, rs2_addr=2 from DECODE; alu_add high for exactly 1 cycle; wr_en=1 with wr_addr=1 three cycles after accept; ovf_flag=0.
REQ-031 Accept instr=0x2C (SUB rd=3, rs2=0) with alu_overflow=1 in EXECUTE -> alu_sub pulse; ovf_flag=1 from WRITEBACK. Then accept 0x70 (CLR rd=0) -> alu_clr pulse; wr_en with wr_addr=0; ovf_flag=0.
REQ-032 Accept 0x95 (undefined) -> illegal=1 from DECODE; no strobes; wr_en stays 0. Then accept 0x31 (AND) -> illegal=0; alu_and pulse.
REQ-033 Hold instr_valid=1 across 0x16, 0x41, 0x00 -> accepts on cycles 0, 4 and 8; instr_ready low for 3 cycles after each accept; NOP produces no strobe and no wr_en.
REQ-034 Assert rst_n=0 in EXECUTE of 0x5B (XOR) -> alu_xor drops immediately; no wr_en; busy=0. After release, instr_ready=1 and the next instruction executes normally.
REQ-035 A checker over all scenarios -> never more than one strobe high at once; wr_en never high outside WRITEBACK.
